// File: rtl/latency_avg_if.sv
// rtl/latency_avg_if.sv - request/result bundle between the latency counter readout and latency_avg
//
// Purpose: groups the start/busy/valid handshake, the two operands and the
// held results of the average-latency divider.
//   master : drives start, issue_cnt, aggregate_cnt; observes results
//   slave  : the divider; observes request, drives busy_r/valid_r/avg_r/rem_r/dbz_r
interface latency_avg_if #(
   parameter int W = 32
);
   logic         start;
   logic [W-1:0] issue_cnt;
   logic [W-1:0] aggregate_cnt;
   logic         busy_r;
   logic         valid_r;
   logic [W-1:0] avg_r;
   logic [W-1:0] rem_r;
   logic         dbz_r;

   modport master (
      output start, issue_cnt, aggregate_cnt,
      input  busy_r, valid_r, avg_r, rem_r, dbz_r
   );

   modport slave (
      input  start, issue_cnt, aggregate_cnt,
      output busy_r, valid_r, avg_r, rem_r, dbz_r
   );
endinterface

// File: rtl/latency_avg.sv
// rtl/latency_avg.sv - W-cycle restoring divider computing average latency = aggregate / issue
//
// Purpose: on start, samples the issue count (divisor) and aggregate pending
// cycles (dividend), runs one quotient bit per clock MSB first, and holds
// quotient, remainder and a divide-by-zero flag until the next completion.
// Ports:
//   clk  : clock, all state updates on posedge
//   rst  : synchronous active-high reset
//   bus  : latency_avg_if.slave (start, issue_cnt, aggregate_cnt in;
//          busy_r, valid_r, avg_r, rem_r, dbz_r out)
module latency_avg #(
   parameter int W = 32
) (
   input  logic          clk,
   input  logic          rst,
   latency_avg_if.slave  bus
);
   localparam int CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      DIV  = 1'b1
   } state_t;

   state_t          state_q, state_d;
   // Dividend shift register; quotient bits enter at the LSB as dividend bits
   // leave at the MSB, so after W steps it holds the full quotient.
   logic [W-1:0]    dvd_q, dvd_d;
   logic [W-1:0]    dsr_q, dsr_d;
   logic [W-1:0]    prem_q, prem_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            valid_q, valid_d;
   logic [W-1:0]    avg_q, avg_d;
   logic [W-1:0]    rem_q, rem_d;
   logic            dbz_q, dbz_d;

   // Restoring step: trial is W+1 bits so the compare/subtract never overflows.
   // The kept remainder is always below the divisor, so W bits suffice to store it.
   logic [W:0]      trial;
   logic            q_bit;
   logic [W-1:0]    rem_nxt;

   always_comb begin
      trial   = {prem_q, dvd_q[W-1]};
      q_bit   = (trial >= {1'b0, dsr_q});
      rem_nxt = q_bit ? W'(trial - {1'b0, dsr_q}) : trial[W-1:0];
   end

   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      dsr_d   = dsr_q;
      prem_d  = prem_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      valid_d = 1'b0;
      avg_d   = avg_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bus.issue_cnt == '0) begin
                  // No requests issued: report zero immediately with the flag set.
                  valid_d = 1'b1;
                  dbz_d   = 1'b1;
                  avg_d   = '0;
                  rem_d   = '0;
               end else begin
                  dvd_d   = bus.aggregate_cnt;
                  dsr_d   = bus.issue_cnt;
                  prem_d  = '0;
                  cnt_d   = CW'(W - 1);
                  busy_d  = 1'b1;
                  state_d = DIV;
               end
            end
         end
         DIV: begin
            prem_d = rem_nxt;
            dvd_d  = {dvd_q[W-2:0], q_bit};
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               avg_d   = {dvd_q[W-2:0], q_bit};
               rem_d   = rem_nxt;
               dbz_d   = 1'b0;
               valid_d = 1'b1;
               busy_d  = 1'b0;
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         dvd_q   <= '0;
         dsr_q   <= '0;
         prem_q  <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         avg_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         dsr_q   <= dsr_d;
         prem_q  <= prem_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         avg_q   <= avg_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   assign bus.busy_r  = busy_q;
   assign bus.valid_r = valid_q;
   assign bus.avg_r   = avg_q;
   assign bus.rem_r   = rem_q;
   assign bus.dbz_r   = dbz_q;
endmodule

// File: tb/tb_latency_avg.sv
// tb/tb_latency_avg.sv - scoreboard bench for latency_avg
module tb_latency_avg;
   localparam int W = 32;

   typedef struct {
      logic [W-1:0] avg;
      logic [W-1:0] rem;
      logic         dbz;
      int           cyc;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_chk;
   int   n_pass;
   exp_t sb[$];

   latency_avg_if #(.W(W)) bus ();

   latency_avg #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: every valid_r pulse must match the oldest queued expectation,
   // including the exact edge on which it appears.
   always @(negedge clk) begin
      if (!rst && bus.valid_r) begin
         chk("busy_low_on_valid", {63'd0, bus.busy_r}, 64'd0);
         if (sb.size() == 0) begin
            chk("unexpected_valid", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("avg", {32'd0, bus.avg_r}, {32'd0, e.avg});
            chk("rem", {32'd0, bus.rem_r}, {32'd0, e.rem});
            chk("dbz", {63'd0, bus.dbz_r}, {63'd0, e.dbz});
            chk("latency", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] r, input logic d, input int lat);
      exp_t e;
      e.avg = a;
      e.rem = r;
      e.dbz = d;
      e.cyc = cyc + lat;
      sb.push_back(e);
   endtask

   task automatic req(input logic [W-1:0] agg, input logic [W-1:0] iss,
                      input logic [W-1:0] eavg, input logic [W-1:0] erem, input logic edbz);
      bus.aggregate_cnt = agg;
      bus.issue_cnt     = iss;
      bus.start         = 1'b1;
      @(posedge clk);
      #1;
      push_exp(eavg, erem, edbz, (iss == 0) ? 0 : W);
      bus.start = 1'b0;
   endtask

   // Waits for the scoreboard to drain, counting busy_r-high cycles on the way.
   task automatic wait_done(input int exp_busy);
      int busy_n;
      int t;
      busy_n = 0;
      t      = 0;
      while (sb.size() != 0 && t < 200) begin
         @(negedge clk);
         #1;
         if (bus.busy_r) busy_n++;
         t++;
      end
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      if (exp_busy >= 0) chk("busy_cycles", 64'(busy_n), 64'(exp_busy));
   endtask

   task automatic check_idle_zero(input string tag);
      @(negedge clk);
      chk({tag, "_busy"},  {63'd0, bus.busy_r},  64'd0);
      chk({tag, "_valid"}, {63'd0, bus.valid_r}, 64'd0);
      chk({tag, "_avg"},   {32'd0, bus.avg_r},   64'd0);
      chk({tag, "_rem"},   {32'd0, bus.rem_r},   64'd0);
      chk({tag, "_dbz"},   {63'd0, bus.dbz_r},   64'd0);
   endtask

   initial begin
      n_chk             = 0;
      n_pass            = 0;
      rst               = 1'b1;
      bus.start         = 1'b0;
      bus.issue_cnt     = '0;
      bus.aggregate_cnt = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check_idle_zero("reset");

      // Basic division
      req(32'd100, 32'd8, 32'd12, 32'd4, 1'b0);
      wait_done(W);

      // Divide by zero, then a normal result clears the flag
      req(32'd55, 32'd0, 32'd0, 32'd0, 1'b1);
      wait_done(0);
      req(32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
      wait_done(W);

      // Operand extremes
      req(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
      wait_done(W);
      req(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
      wait_done(W);
      req(32'd7, 32'hFFFF_FFFF, 32'd0, 32'd7, 1'b0);
      wait_done(W);

      // start and operand churn while busy must not disturb 1000/7
      req(32'd1000, 32'd7, 32'd142, 32'd6, 1'b0);
      for (int i = 0; i < W - 1; i++) begin
         bus.start         = 1'b1;
         bus.aggregate_cnt = 32'd50 + 32'(i);
         bus.issue_cnt     = 32'd5 + 32'(i);
         @(posedge clk);
         #1;
      end
      bus.start = 1'b0;
      wait_done(1);
      repeat (5) @(posedge clk);
      #1;

      // Reset mid-division aborts with no valid pulse
      bus.aggregate_cnt = 32'd20;
      bus.issue_cnt     = 32'd3;
      bus.start         = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_idle_zero("abort");
      repeat (40) @(posedge clk);
      #1;
      req(32'd20, 32'd3, 32'd6, 32'd2, 1'b0);
      wait_done(W);

      // start held high: a new division is accepted in each valid cycle
      bus.aggregate_cnt = 32'd64;
      bus.issue_cnt     = 32'd4;
      bus.start         = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         push_exp(32'd16, 32'd0, 1'b0, W);
         repeat (W) @(posedge clk);
         #1;
      end
      bus.start = 1'b0;
      wait_done(-1);
      repeat (40) @(posedge clk);
      #1;
      chk("final_idle_busy", {63'd0, bus.busy_r}, 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
